// File: rtl/ysyx_23060187_ifu_if.sv
// rtl/ysyx_23060187_ifu_if.sv - fetch-side bus bundle between the IFU, instruction memory and decode
interface ysyx_23060187_ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_cnt;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_cnt,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_cnt,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ysyx_23060187_ifu.sv
// rtl/ysyx_23060187_ifu.sv - single-outstanding instruction fetch unit with redirect/kill handling
module ysyx_23060187_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  ysyx_23060187_ifu_if.master    bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        kill_q, kill_d;
  logic        run_q, run_d;
  logic        req_hs;
  logic        inst_hs;

  // run_q keeps the request line low until the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      inst_q    <= 32'd0;
      inst_pc_q <= 32'd0;
      cnt_q     <= 32'd0;
      kill_q    <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      cnt_q     <= cnt_d;
      kill_q    <= kill_d;
      run_q     <= run_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    cnt_d     = cnt_q;
    kill_d    = kill_q;
    run_d     = 1'b1;
    req_hs    = (state_q == S_REQ) && run_q && bus.imem_req_ready;
    inst_hs   = (state_q == S_HOLD) && bus.inst_ready;

    case (state_q)
      S_REQ: begin
        if (bus.redirect_valid) pc_d = bus.redirect_pc;
        if (req_hs) begin
          state_d = S_WAIT;
          kill_d  = bus.redirect_valid;
        end
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          state_d = S_REQ;
          kill_d  = 1'b0;
          if (bus.redirect_valid) begin
            pc_d = bus.redirect_pc;
          end else if (!kill_q) begin
            state_d   = S_HOLD;
            inst_d    = bus.imem_rsp_data;
            inst_pc_d = pc_q;
          end
        end else if (bus.redirect_valid) begin
          pc_d   = bus.redirect_pc;
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        // a delivered instruction still counts even when a redirect wins the PC
        if (inst_hs) begin
          cnt_d   = cnt_q + 32'd1;
          pc_d    = bus.redirect_valid ? bus.redirect_pc : pc_q + 32'd4;
          state_d = S_REQ;
        end else if (bus.redirect_valid) begin
          pc_d    = bus.redirect_pc;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  assign bus.imem_req_valid = (state_q == S_REQ) && run_q;
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = (state_q == S_HOLD);
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.fetch_cnt      = cnt_q;

endmodule

// File: tb/tb_ysyx_23060187_ifu.sv
// tb/tb_ysyx_23060187_ifu.sv - randomized bench for the IFU against a transaction-level fetch model
module tb_ysyx_23060187_ifu;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_23060187_ifu_if bus();
  ysyx_23060187_ifu #(.RESET_PC(RESET_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // model: architectural next-fetch PC, delivery count, pending deliverable words
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  exp_t        exp_q[$];
  // memory: one outstanding request, its address, latency and staleness
  bit          mem_out;
  bit          mem_stale;
  logic [31:0] mem_addr;
  int          mem_wait;
  int          fixed_lat;
  bit          noise;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == RESET_PC) ? 32'h0000_0413 : (a ^ 32'h1357_9BDF);
  endfunction

  task automatic step();
    logic [31:0] pc0;
    logic        exp_req;
    logic        hs;
    logic        ihs;
    logic        rsp;
    if (mem_out) begin
      bus.imem_rsp_valid = (mem_wait == 0);
      bus.imem_rsp_data  = mem_stale ? 32'hDEAD_BEEF : mem_word(mem_addr);
      if (mem_wait > 0) mem_wait--;
    end else if (noise && $urandom_range(7) == 0) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = $urandom;
    end else begin
      bus.imem_rsp_valid = 1'b0;
    end
    @(negedge clk);
    exp_req = !mem_out && (exp_q.size() == 0);
    check_eq("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
    check_eq("req_addr", bus.imem_req_addr, m_pc);
    check_eq("inst_valid", 32'(bus.inst_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check_eq("inst", bus.inst, exp_q[0].data);
      check_eq("inst_pc", bus.inst_pc, exp_q[0].pc);
    end
    check_eq("fetch_cnt", bus.fetch_cnt, m_cnt);

    pc0 = m_pc;
    hs  = exp_req && bus.imem_req_ready;
    ihs = (exp_q.size() != 0) && bus.inst_ready;
    rsp = mem_out && bus.imem_rsp_valid;
    if (rsp) begin
      if (!mem_stale && !bus.redirect_valid) exp_q.push_back('{mem_word(mem_addr), mem_addr});
      mem_out = 0;
    end
    if (ihs) begin
      m_cnt = m_cnt + 32'd1;
      m_pc  = exp_q[0].pc + 32'd4;
      exp_q.pop_front();
    end
    if (bus.redirect_valid) begin
      m_pc = bus.redirect_pc;
      if (exp_q.size() != 0) exp_q.pop_front();
      if (mem_out) mem_stale = 1;
    end
    if (hs) begin
      mem_out   = 1;
      mem_addr  = pc0;
      mem_stale = bus.redirect_valid;
      mem_wait  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(2));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bit orphan;
    orphan = mem_out;
    bus.imem_req_ready = 1'b0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    rst = 1'b0;
    mem_out = 0;
    exp_q.delete();
    m_pc  = RESET_PC;
    m_cnt = 32'd0;
    @(negedge clk);
    check_eq("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check_eq("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check_eq("rst_inst", bus.inst, 32'd0);
    check_eq("rst_inst_pc", bus.inst_pc, 32'd0);
    check_eq("rst_fetch_cnt", bus.fetch_cnt, 32'd0);
    check_eq("rst_req_addr", bus.imem_req_addr, RESET_PC);
    @(posedge clk);
    #1;
    rst = 1'b1;
    // a response left over from before reset lands in the release cycle
    bus.imem_rsp_valid = orphan;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("release_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check_eq("release_inst_valid", 32'(bus.inst_valid), 32'd0);
    @(posedge clk);
    #1;
    bus.imem_rsp_valid = 1'b0;
  endtask

  task automatic wait_inst();
    for (int i = 0; i < 16; i++) begin
      if (exp_q.size() != 0) break;
      step();
    end
    if (exp_q.size() == 0) check_eq("wait_inst_timeout", 32'(exp_q.size()), 32'd1);
  endtask

  task automatic redirect_now(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'd0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    mem_out   = 0;
    mem_stale = 0;
    mem_addr  = 32'd0;
    mem_wait  = 0;
    fixed_lat = 0;
    noise     = 0;
    m_pc      = RESET_PC;
    m_cnt     = 32'd0;
    #2;
    do_reset();

    // first fetch with single-cycle memory
    bus.imem_req_ready = 1'b1;
    check_eq("first_addr", bus.imem_req_addr, 32'h8000_0000);
    wait_inst();
    check_eq("s1_inst", bus.inst, 32'h0000_0413);
    check_eq("s1_inst_pc", bus.inst_pc, 32'h8000_0000);
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    check_eq("s1_next_addr", bus.imem_req_addr, 32'h8000_0004);
    check_eq("s1_cnt", bus.fetch_cnt, 32'd1);

    // decode backpressure for five cycles
    wait_inst();
    bus.imem_req_ready = 1'b0;
    repeat (5) step();
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    check_eq("s2_cnt", bus.fetch_cnt, 32'd2);

    // redirect in WAIT, stale response three cycles later
    fixed_lat = 3;
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    redirect_now(32'h8000_0100);
    repeat (4) step();
    check_eq("s3_inst_valid", 32'(bus.inst_valid), 32'd0);
    check_eq("s3_next_addr", bus.imem_req_addr, 32'h8000_0100);

    // redirect together with inst_ready in HOLD
    fixed_lat = 0;
    redirect_now(32'h8000_0010);
    bus.imem_req_ready = 1'b1;
    wait_inst();
    bus.imem_req_ready = 1'b0;
    check_eq("s4_inst_pc", bus.inst_pc, 32'h8000_0010);
    bus.inst_ready = 1'b1;
    redirect_now(32'h8000_0040);
    bus.inst_ready = 1'b0;
    check_eq("s4_cnt", bus.fetch_cnt, 32'd3);
    check_eq("s4_next_addr", bus.imem_req_addr, 32'h8000_0040);

    // PC wrap at the top of the address space
    redirect_now(32'hFFFF_FFFC);
    bus.imem_req_ready = 1'b1;
    wait_inst();
    bus.imem_req_ready = 1'b0;
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    check_eq("s5_wrap_addr", bus.imem_req_addr, 32'h0000_0000);
    check_eq("s5_cnt", bus.fetch_cnt, 32'd4);

    // reset pulled while a request is outstanding
    fixed_lat = 2;
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    step();
    do_reset();
    step();
    check_eq("s6_addr", bus.imem_req_addr, RESET_PC);
    check_eq("s6_cnt", bus.fetch_cnt, 32'd0);
    check_eq("s6_inst_valid", 32'(bus.inst_valid), 32'd0);

    // randomized traffic
    fixed_lat = -1;
    noise     = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(299) == 0) do_reset();
      bus.imem_req_ready = ($urandom_range(3) != 0);
      bus.inst_ready     = ($urandom_range(1) != 0);
      bus.redirect_valid = ($urandom_range(9) == 0);
      r = $urandom;
      r[1:0] = 2'b00;
      if ($urandom_range(3) == 0) r = 32'hFFFF_FFFC;
      bus.redirect_pc = r;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
